life_controller: RTL and testbench



---
 rtl/life_pkg.sv | 21 ++
 rtl/life_tick_gen.sv | 38 +++
 rtl/life_controller.sv | 155 +++++++++++++++
 tb/tb_life_controller.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// life_pkg: shared definitions for the Game of Life control stage.
//   GRID_DIM / GRID_W : board edge length and flattened cell count.
//   life_state_t      : controller state (IDLE, RUN, PAUSED, HALT).
//   cell_index()      : flattened bit index of a cell, row*GRID_DIM+col.
package life_pkg;

    localparam int GRID_DIM = 8;
    localparam int GRID_W   = GRID_DIM * GRID_DIM;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        HALT
    } life_state_t;

    function automatic int cell_index(input int row, input int col);
        return row * GRID_DIM + col;
    endfunction

endpackage

// File: rtl/life_tick_gen.sv
// life_tick_gen: generation-rate divider for the RUN state.
//   clk, reset : clock and asynchronous active-high reset.
//   enable     : count this cycle (controller is running and not pausing).
//   restart    : force the count back to 0 (fresh run, clear, load).
//   tick       : high in the cycle where the count sits at TICK_DIV-1 and
//                enable is high; the count wraps to 0 on that edge.
module life_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    // A one-bit counter is kept for TICK_DIV == 1; it then never leaves 0,
    // so every enabled cycle ticks.
    localparam int                CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    assign tick = enable && (count == LAST);

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values, independent of the order the always blocks run in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/life_controller.sv
// life_controller: sequential control stage around the combinational evolve
// datapath. Holds the current generation, commits grid_next on ticks or
// single steps, and reports halt conditions.
//   clk, reset  : clock and asynchronous active-high reset.
//   clear, load : zero the grid / capture seed; both return to IDLE.
//   seed        : initial pattern, bit index = row*8+col.
//   start, pause, step : run control (priority clear>load>pause>step>start).
//   grid_next   : next generation from the evolve datapath.
//   grid        : registered current generation, fed to the datapath.
//   generation  : number of committed generations (wraps).
//   running, halted : decoded RUN / HALT state.
//   stable      : a commit attempt found grid_next == grid.
//   extinct     : last committed grid was all zero.
//   gen_strobe  : one-cycle pulse in the first cycle a new grid is visible.
module life_controller
    import life_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int GEN_W    = 16,
    parameter int MAX_GEN  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [GRID_W-1:0] seed,
    input  logic              start,
    input  logic              pause,
    input  logic              step,
    input  logic [GRID_W-1:0] grid_next,
    output logic [GRID_W-1:0] grid,
    output logic [GEN_W-1:0]  generation,
    output logic              running,
    output logic              halted,
    output logic              stable,
    output logic              extinct,
    output logic              gen_strobe
);

    life_state_t       state, state_d;
    logic [GRID_W-1:0] grid_d;
    logic [GEN_W-1:0]  generation_d;
    logic              stable_d, extinct_d, strobe_d;
    logic              attempt, restart, tick_en, tick;

    // Counting stops in any cycle where a higher-priority command acts, so a
    // pause mid-count freezes the counter where it stood.
    assign tick_en = (state == RUN) && !clear && !load && !pause;

    life_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .enable  (tick_en),
        .restart (restart),
        .tick    (tick)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state;
        grid_d       = grid;
        generation_d = generation;
        stable_d     = stable;
        extinct_d    = extinct;
        strobe_d     = 1'b0;
        attempt      = 1'b0;
        restart      = 1'b0;

        if (clear || load) begin
            grid_d       = clear ? '0 : seed;
            generation_d = '0;
            stable_d     = 1'b0;
            extinct_d    = 1'b0;
            restart      = 1'b1;
            state_d      = IDLE;
        end else begin
            // An asserted pause outranks step/start even where it has no
            // effect of its own (IDLE, PAUSED, HALT).
            unique case (state)
                IDLE: begin
                    if (!pause) begin
                        if (step) begin
                            attempt = 1'b1;
                        end else if (start) begin
                            state_d = RUN;
                            restart = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSED;
                    end else begin
                        attempt = tick;
                    end
                end
                PAUSED: begin
                    // Resuming keeps the held count, so the next commit
                    // comes after the remainder of the interrupted interval.
                    if (!pause) begin
                        if (step) begin
                            attempt = 1'b1;
                        end else if (start) begin
                            state_d = RUN;
                        end
                    end
                end
                HALT: begin
                end
                default: begin
                end
            endcase

            if (attempt) begin
                if (grid_next == grid) begin
                    stable_d = 1'b1;
                    state_d  = HALT;
                end else begin
                    grid_d       = grid_next;
                    generation_d = generation + 1'b1;
                    extinct_d    = (grid_next == '0);
                    strobe_d     = 1'b1;
                    if (MAX_GEN != 0 && generation_d == GEN_W'(MAX_GEN)) begin
                        state_d = HALT;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grid       <= '0;
            generation <= '0;
            stable     <= 1'b0;
            extinct    <= 1'b0;
            gen_strobe <= 1'b0;
        end else begin
            state      <= state_d;
            grid       <= grid_d;
            generation <= generation_d;
            stable     <= stable_d;
            extinct    <= extinct_d;
            gen_strobe <= strobe_d;
        end
    end

    assign running = (state == RUN);
    assign halted  = (state == HALT);

endmodule

// File: tb/tb_life_controller.sv
// tb_life_controller: closes the loop between life_controller and a
// behavioural evolve datapath (dead cells beyond the board edge). A
// high-level model predicts each commit attempt and pushes the expected
// result; a monitor pops and compares whenever the DUT shows gen_strobe or
// newly raises halted. A second instance (TICK_DIV=1, MAX_GEN=3) covers the
// generation limit.
module tb_life_controller;
    import life_pkg::*;

    localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
    localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
    localparam logic [63:0] LONE    = 64'h0000_0000_0800_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, step = 1'b0;
    logic [63:0] seed = '0;
    logic [63:0] grid_next, grid;
    logic [15:0] generation;
    logic        running, halted, stable, extinct, gen_strobe;

    logic        lim_load = 1'b0, lim_start = 1'b0;
    logic [63:0] lim_seed = '0;
    logic [63:0] lim_grid_next, lim_grid;
    logic [15:0] lim_generation;
    logic        lim_running, lim_halted, lim_stable, lim_extinct, lim_strobe;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Conway rule: birth on 3 neighbours, survival on 2 or 3.
    function automatic logic [63:0] life_next(input logic [63:0] g);
        logic [63:0] n;
        n = '0;
        for (int r = 0; r < GRID_DIM; r++) begin
            for (int c = 0; c < GRID_DIM; c++) begin
                int cnt;
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < GRID_DIM &&
                            c + dc >= 0 && c + dc < GRID_DIM &&
                            g[cell_index(r + dr, c + dc)]) begin
                            cnt++;
                        end
                    end
                end
                n[cell_index(r, c)] = (cnt == 3) || (g[cell_index(r, c)] && cnt == 2);
            end
        end
        return n;
    endfunction

    assign grid_next     = life_next(grid);
    assign lim_grid_next = life_next(lim_grid);

    life_controller #(.TICK_DIV(4), .GEN_W(16), .MAX_GEN(0)) dut (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .seed(seed),
        .start(start), .pause(pause), .step(step), .grid_next(grid_next),
        .grid(grid), .generation(generation), .running(running),
        .halted(halted), .stable(stable), .extinct(extinct),
        .gen_strobe(gen_strobe)
    );

    life_controller #(.TICK_DIV(1), .GEN_W(16), .MAX_GEN(3)) dut_lim (
        .clk(clk), .reset(reset), .clear(1'b0), .load(lim_load), .seed(lim_seed),
        .start(lim_start), .pause(1'b0), .step(1'b0), .grid_next(lim_grid_next),
        .grid(lim_grid), .generation(lim_generation), .running(lim_running),
        .halted(lim_halted), .stable(lim_stable), .extinct(lim_extinct),
        .gen_strobe(lim_strobe)
    );

    typedef struct {
        logic [63:0] grid;
        logic [15:0] gen;
        logic        stable;
        logic        extinct;
        logic        halted;
    } exp_t;

    exp_t exp_q[$];

    logic [63:0] m_grid;
    logic [15:0] m_gen;
    logic        m_stable, m_extinct, m_halted;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_set(input logic [63:0] g);
        m_grid    = g;
        m_gen     = '0;
        m_stable  = 1'b0;
        m_extinct = 1'b0;
        m_halted  = 1'b0;
    endtask

    // One commit attempt as seen from the outside: either the board is a
    // fixed point (halt, nothing else changes) or the next board is shown.
    task automatic model_attempt();
        logic [63:0] nxt;
        exp_t e;
        if (m_halted) return;
        nxt = life_next(m_grid);
        if (nxt == m_grid) begin
            m_stable = 1'b1;
            m_halted = 1'b1;
        end else begin
            m_grid    = nxt;
            m_gen     = m_gen + 16'd1;
            m_extinct = (nxt == '0);
        end
        e.grid    = m_grid;
        e.gen     = m_gen;
        e.stable  = m_stable;
        e.extinct = m_extinct;
        e.halted  = m_halted;
        exp_q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic c_clear, input logic c_load, input logic c_pause,
                         input logic c_step, input logic c_start, input logic [63:0] s);
        clear = c_clear; load = c_load; pause = c_pause; step = c_step; start = c_start;
        seed  = s;
        cycles(1);
        clear = 1'b0; load = 1'b0; pause = 1'b0; step = 1'b0; start = 1'b0;
    endtask

    task automatic drain_check(input string name);
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Monitor: one pop per visible commit or halt event.
    logic halted_q = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (gen_strobe || (halted && !halted_q))) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_event: got gen %0d grid %h, expected no event",
                         generation, grid);
            end else begin
                e = exp_q.pop_front();
                check("sb_grid", grid, e.grid);
                check("sb_generation", 64'(generation), 64'(e.gen));
                check("sb_stable", 64'(stable), 64'(e.stable));
                check("sb_extinct", 64'(extinct), 64'(e.extinct));
                check("sb_halted", 64'(halted), 64'(e.halted));
            end
        end
        halted_q = halted;
    end

    initial begin
        logic [63:0] s;
        int          n;

        model_set('0);
        #3;
        check("rst_grid", grid, 64'd0);
        check("rst_generation", 64'(generation), 64'd0);
        check("rst_flags", {59'd0, running, halted, stable, extinct, gen_strobe}, 64'd0);
        check("rst_lim_grid", lim_grid, 64'd0);
        #9 reset = 1'b0;
        cycles(1);

        // Blinker, TICK_DIV=4: commits 4 and 8 cycles after start.
        pulse(0, 1, 0, 0, 0, BLINK_H);
        model_set(BLINK_H);
        check("blink_loaded", grid, BLINK_H);
        pulse(0, 0, 0, 0, 1, '0);
        check("blink_running", 64'(running), 64'd1);
        model_attempt();
        cycles(3);
        check("blink_no_early_commit", 64'(generation), 64'd0);
        cycles(1);
        check("blink_gen1_grid", grid, BLINK_V);
        check("blink_gen1_count", 64'(generation), 64'd1);
        check("blink_strobe_high", 64'(gen_strobe), 64'd1);
        cycles(1);
        check("blink_strobe_one_cycle", 64'(gen_strobe), 64'd0);
        model_attempt();
        cycles(3);
        check("blink_gen2_grid", grid, BLINK_H);
        check("blink_gen2_count", 64'(generation), 64'd2);

        // Pause two counts into the interval, hold, step, then resume.
        cycles(2);
        pulse(0, 0, 1, 0, 0, '0);
        check("pause_not_running", 64'(running), 64'd0);
        cycles(6);
        check("pause_grid_frozen", grid, BLINK_H);
        check("pause_gen_frozen", 64'(generation), 64'd2);
        model_attempt();
        pulse(0, 0, 0, 1, 0, '0);
        check("step_grid", grid, BLINK_V);
        check("step_gen", 64'(generation), 64'd3);
        cycles(2);
        check("step_only_once", 64'(generation), 64'd3);
        pulse(0, 0, 0, 0, 1, '0);
        model_attempt();
        cycles(1);
        check("resume_wait_remaining", 64'(generation), 64'd3);
        cycles(1);
        check("resume_commit_gen", 64'(generation), 64'd4);
        check("resume_commit_grid", grid, BLINK_H);
        pulse(1, 1, 0, 0, 0, 64'hFFFF_0000_FFFF_0000);
        model_set('0);
        check("clear_beats_load", grid, 64'd0);
        check("clear_gen", 64'(generation), 64'd0);
        check("clear_idle", 64'(running), 64'd0);
        drain_check("blink_queue_empty");

        // Block still life: halts on first tick, then ignores run controls.
        pulse(0, 1, 0, 0, 0, BLOCK);
        model_set(BLOCK);
        pulse(0, 0, 0, 0, 1, '0);
        model_attempt();
        cycles(4);
        check("block_stable", 64'(stable), 64'd1);
        check("block_halted", 64'(halted), 64'd1);
        check("block_gen", 64'(generation), 64'd0);
        pulse(0, 0, 0, 0, 1, '0);
        pulse(0, 0, 0, 1, 0, '0);
        pulse(0, 0, 1, 0, 0, '0);
        cycles(8);
        check("block_still_halted", 64'(halted), 64'd1);
        check("block_grid", grid, BLOCK);
        check("block_gen_after", 64'(generation), 64'd0);
        drain_check("block_queue_empty");
        pulse(1, 0, 0, 0, 0, '0);
        model_set('0);

        // Lone cell: dies on first step, halts on the second.
        pulse(0, 1, 0, 0, 0, LONE);
        model_set(LONE);
        model_attempt();
        pulse(0, 0, 0, 1, 0, '0);
        check("lone_grid", grid, 64'd0);
        check("lone_extinct", 64'(extinct), 64'd1);
        check("lone_gen", 64'(generation), 64'd1);
        check("lone_not_halted", 64'(halted), 64'd0);
        model_attempt();
        pulse(0, 0, 0, 1, 0, '0);
        check("lone_stable", 64'(stable), 64'd1);
        check("lone_halted", 64'(halted), 64'd1);
        check("lone_gen_held", 64'(generation), 64'd1);
        cycles(1);
        drain_check("lone_queue_empty");
        pulse(1, 0, 0, 0, 0, '0);
        model_set('0);

        // Random seeds run for a random number of tick intervals.
        for (int it = 0; it < 24; it++) begin
            if (it % 3 == 0) s = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            else             s = {$urandom, $urandom};
            pulse(0, 1, 0, 0, 0, s);
            model_set(s);
            pulse(0, 0, 0, 0, 1, '0);
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) begin
                model_attempt();
                cycles(4);
            end
            cycles(1);
            drain_check("rand_queue_empty");
            check("rand_grid", grid, m_grid);
            check("rand_gen", 64'(generation), 64'(m_gen));
            pulse(1, 0, 0, 0, 0, '0);
            model_set('0);
        end

        // Generation limit on the TICK_DIV=1 instance.
        lim_seed = BLINK_H;
        lim_load = 1'b1;
        cycles(1);
        lim_load  = 1'b0;
        lim_start = 1'b1;
        cycles(1);
        lim_start = 1'b0;
        cycles(1);
        check("lim_gen1", 64'(lim_generation), 64'd1);
        cycles(2);
        check("lim_gen3", 64'(lim_generation), 64'd3);
        check("lim_halted", 64'(lim_halted), 64'd1);
        check("lim_not_stable", 64'(lim_stable), 64'd0);
        check("lim_grid", lim_grid, BLINK_V);
        cycles(3);
        check("lim_gen_held", 64'(lim_generation), 64'd3);

        // Asynchronous reset between clock edges in the middle of a run.
        pulse(0, 1, 0, 0, 0, BLINK_H);
        pulse(0, 0, 0, 0, 1, '0);
        cycles(2);
        #2 reset = 1'b1;
        #1;
        check("arst_grid", grid, 64'd0);
        check("arst_gen", 64'(generation), 64'd0);
        check("arst_flags", {59'd0, running, halted, stable, extinct, gen_strobe}, 64'd0);
        check("arst_lim", {lim_grid[62:0], lim_halted}, 64'd0);
        reset = 1'b0;
        model_set('0);
        cycles(6);
        check("arst_stays_idle", 64'(generation), 64'd0);
        drain_check("final_queue_empty");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
